uart_rx_fifo: RTL

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

---
 rtl/uart_rx_fifo.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_fifo.sv
// UART receiver: synchronizer, majority filter, frame decoder with parity/framing/break
// detection, first-word fall-through RX FIFO and idle-line receive timeout.
module uart_rx_fifo #(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned DIV_W   = 16,
  parameter int unsigned TO_BITS = 40
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         io_en,
  input  logic                         io_in,
  input  logic [DIV_W-1:0]             io_div,
  input  logic [7:0]                   LCR,
  output logic                         io_out_valid,
  input  logic                         io_out_ready,
  output logic [7:0]                   io_out_bits,
  output logic [2:0]                   io_out_err,
  output logic [$clog2(DEPTH+1)-1:0]   io_count,
  output logic                         io_overrun,
  output logic                         io_timeout,
  output logic                         rx_idle
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH+1);
  localparam int unsigned TW = $clog2(TO_BITS+1);
  localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2, PUSH} state_e;

  logic [1:0]       sync_q;
  logic [2:0]       maj_q;
  logic             filt_q;
  state_e           state_q;
  logic [DIV_W-1:0] baud_q;
  logic [2:0]       bit_q;
  logic [7:0]       data_q;
  logic             perr_q, ferr_q, allz_q, rearm_q;
  logic [10:0]      mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             ovr_q;
  logic [DIV_W-1:0] fr_q;
  logic [TW-1:0]    tc_q;

  logic baud_zero, fr_zero, start_det, pop, push_req, full, do_push, maj3;
  logic unused_lcr;

  assign unused_lcr = ^LCR[7:6];
  assign maj3       = (maj_q[0] & maj_q[1]) | (maj_q[0] & maj_q[2]) | (maj_q[1] & maj_q[2]);
  assign baud_zero  = (baud_q == '0);
  assign fr_zero    = (fr_q == '0);
  assign start_det  = (state_q == IDLE) && io_en && (io_div >= DIV_W'(2)) && !filt_q && !rearm_q;
  assign pop        = io_out_valid & io_out_ready;
  assign push_req   = (state_q == PUSH);
  assign full       = (count_q == CW'(DEPTH));
  assign do_push    = push_req & (~full | pop);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_q <= '1;
      maj_q  <= '1;
      filt_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[0], io_in};
      maj_q  <= {maj_q[1:0], sync_q[1]};
      filt_q <= maj3;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      data_q  <= '0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      allz_q  <= 1'b1;
      rearm_q <= 1'b0;
    end else begin
      if (filt_q) rearm_q <= 1'b0;
      if (state_q != IDLE && state_q != PUSH)
        baud_q <= baud_zero ? io_div - ONE : baud_q - ONE;
      // Disabling aborts any partial frame; a frame already in PUSH still completes.
      if (!io_en && state_q != IDLE && state_q != PUSH) begin
        state_q <= IDLE;
      end else begin
        case (state_q)
          IDLE: if (start_det) begin
            state_q <= START;
            baud_q  <= (io_div >> 1) - ONE;
            bit_q   <= '0;
            data_q  <= '0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            allz_q  <= 1'b1;
          end
          START: if (baud_zero) state_q <= filt_q ? IDLE : DATA;
          DATA: if (baud_zero) begin
            data_q[bit_q] <= filt_q;
            allz_q        <= allz_q & ~filt_q;
            if (bit_q >= {1'b1, LCR[1:0]}) state_q <= LCR[3] ? PARITY : STOP1;
            else                           bit_q   <= bit_q + 3'd1;
          end
          PARITY: if (baud_zero) begin
            perr_q  <= ((LCR[5] ? filt_q : (^data_q ^ filt_q)) == LCR[4]);
            allz_q  <= allz_q & ~filt_q;
            state_q <= STOP1;
          end
          STOP1: if (baud_zero) begin
            ferr_q  <= ferr_q | ~filt_q;
            allz_q  <= allz_q & ~filt_q;
            state_q <= LCR[2] ? STOP2 : PUSH;
          end
          STOP2: if (baud_zero) begin
            ferr_q  <= ferr_q | ~filt_q;
            allz_q  <= allz_q & ~filt_q;
            state_q <= PUSH;
          end
          PUSH: begin
            state_q <= IDLE;
            if (allz_q) rearm_q <= 1'b1;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  always_comb begin
    count_d = count_q;
    case ({do_push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (do_push) mem_q[wptr_q] <= {allz_q, ferr_q, perr_q, data_q};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovr_q   <= 1'b0;
    end else begin
      if (do_push) wptr_q <= wptr_q + AW'(1);
      if (pop)     rptr_q <= rptr_q + AW'(1);
      count_q <= count_d;
      ovr_q   <= push_req & full & ~pop;
    end
  end

  // Timeout strobes come from a free-running divider so they tick while the decoder is idle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fr_q <= '0;
      tc_q <= '0;
    end else begin
      fr_q <= fr_zero ? io_div - ONE : fr_q - ONE;
      if (start_det || pop)
        tc_q <= '0;
      else if (state_q == IDLE && count_q != '0 && fr_zero && tc_q != TW'(TO_BITS))
        tc_q <= tc_q + TW'(1);
    end
  end

  assign io_out_valid = (count_q != '0);
  assign io_out_bits  = io_out_valid ? mem_q[rptr_q][7:0]  : '0;
  assign io_out_err   = io_out_valid ? mem_q[rptr_q][10:8] : '0;
  assign io_count     = count_q;
  assign io_overrun   = ovr_q;
  assign io_timeout   = (tc_q == TW'(TO_BITS));
  assign rx_idle      = (state_q == IDLE);

endmodule
